// File: rtl/deserializador_param_if.sv
// Handshake and serial-stream bundle for deserializador_param.
// master: the side driving the serial stream and the acknowledge (link + consumer).
// slave:  the deserialiser itself.
interface deserializador_param_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             write_in;
  logic             ack_in;
  logic             clr_ovf;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             status_out;
  logic             overflow;

  modport master (
    output data_in, write_in, ack_in, clr_ovf,
    input  data_out, data_ready, status_out, overflow
  );

  modport slave (
    input  data_in, write_in, ack_in, clr_ovf,
    output data_out, data_ready, status_out, overflow
  );
endinterface

// File: rtl/deserializador_param.sv
// Parametrised serial-to-parallel converter.
// Collects WIDTH write_in-qualified bits, presents each word on a four-phase
// data_ready/ack_in handshake, buffers one extra word while the consumer is busy,
// and flags bits that arrive while that buffer is full.
module deserializador_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                  clk_100KHz,
  input logic                  reset,
  deserializador_param_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    H_ACK
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] pend_word, out_word;
  logic [CW-1:0]    count;
  logic             pend_full, ovf;
  logic             accept, drop, word_done;
  logic             load_pend, load_new;

  // A bit is taken only while the pending buffer has room; otherwise it is lost.
  assign accept    = bus.write_in && !pend_full;
  assign drop      = bus.write_in &&  pend_full;
  assign word_done = accept && (count == LAST);

  // Shift register value after taking the current bit, in the configured order.
  always_comb begin
    if (MSB_FIRST) shift_next = {shift_reg[WIDTH-2:0], bus.data_in};
    else           shift_next = {bus.data_in, shift_reg[WIDTH-1:1]};
  end

  // Bit collection: shift and count, restart cleanly once a word completes.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      count     <= '0;
    end else if (accept) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (word_done) begin
        shift_reg <= '0;
        count     <= '0;
      end else begin
        shift_reg <= shift_next;
        count     <= count + 1'b1;
      end
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Handshake next state; a buffered word takes priority over a fresh one in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next = state;
    load_pend  = 1'b0;
    load_new   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          load_pend  = 1'b1;
          state_next = SEND;
        end else if (word_done) begin
          load_new   = 1'b1;
          state_next = SEND;
        end
      end
      SEND:    if (bus.ack_in)  state_next = H_ACK;
      H_ACK:   if (!bus.ack_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Presented word and the one-deep pending buffer.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      // NOTE: the pending word is a single register, so it is reset like any other flop.
      out_word  <= '0;
      pend_word <= '0;
      pend_full <= 1'b0;
    end else begin
      if (load_pend)                        out_word <= pend_word;
      else if (load_new)                    out_word <= shift_next;
      else if (state == H_ACK && !bus.ack_in) out_word <= '0;

      if (load_pend) begin
        pend_full <= 1'b0;
      end else if (word_done && !load_new) begin
        pend_word <= shift_next;
        pend_full <= 1'b1;
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset)            ovf <= 1'b0;
    else if (drop)         ovf <= 1'b1;
    else if (bus.clr_ovf)  ovf <= 1'b0;
  end

  assign bus.data_out   = out_word;
  assign bus.data_ready = (state != IDLE);
  assign bus.status_out = pend_full;
  assign bus.overflow   = ovf;

endmodule
